// File: rtl/instr_fetch_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | instr_fetch_seq : fetch/decode/execute sequencer with PC and return stack  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module instr_fetch_seq #(
  parameter logic [10:0] RESET_VEC   = 11'h000,
  parameter int          STACK_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  output logic [10:0] Rom_addr_out,
  input  logic [13:0] Rom_data_in,
  input  logic        stall,
  input  logic        skip_req,
  output logic [13:0] ir_out,
  output logic        ir_valid,
  output logic [10:0] pc_out,
  output logic        stack_err
);

  localparam int SPW = $clog2(STACK_DEPTH);
  localparam int OCW = $clog2(STACK_DEPTH + 1);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [OCW-1:0] OC_ONE  = OCW'(1);
  localparam logic [OCW-1:0] OC_ZERO = '0;
  localparam logic [OCW-1:0] OC_FULL = OCW'(STACK_DEPTH);

  localparam logic [1:0] K_SEQ  = 2'd0;
  localparam logic [1:0] K_GOTO = 2'd1;
  localparam logic [1:0] K_CALL = 2'd2;
  localparam logic [1:0] K_RET  = 2'd3;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2
  } state_t;

  state_t         state, state_next;
  logic [10:0]    pc, pc_next, pc_inc;
  logic [13:0]    ir;
  logic [SPW-1:0] sp, sp_next;
  logic [OCW-1:0] occ, occ_next;
  logic           squash, squash_next;
  logic           err_next;
  logic           push;
  logic [1:0]     kind, dec_kind;
  logic [10:0]    target, dec_target;
  logic [10:0]    stack [STACK_DEPTH];

  assign pc_inc       = pc + 11'd1;
  assign Rom_addr_out = pc;
  assign pc_out       = pc;
  assign ir_out       = ir;
  assign ir_valid     = (state == EXEC) && !squash;

  // Return target is read here; the stack cannot change before EXEC commits.
  always_comb begin
    dec_kind   = K_SEQ;
    dec_target = ir[10:0];
    if (ir[13:11] == 3'b101) begin
      dec_kind = K_GOTO;
    end else if (ir[13:11] == 3'b100) begin
      dec_kind = K_CALL;
    end else if (ir == 14'h0008 || ir[13:10] == 4'b1101) begin
      dec_kind   = K_RET;
      dec_target = stack[sp - SP_ONE];
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    sp_next     = sp;
    occ_next    = occ;
    squash_next = squash;
    err_next    = stack_err;
    push        = 1'b0;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: state_next = EXEC;
      EXEC: begin
        state_next  = FETCH;
        squash_next = skip_req & ~squash;
        pc_next     = pc_inc;
        if (!squash) begin
          case (kind)
            K_GOTO: pc_next = target;
            K_CALL: begin
              push    = 1'b1;
              pc_next = target;
              sp_next = sp + SP_ONE;
              if (occ == OC_FULL) err_next = 1'b1;
              else                occ_next = occ + OC_ONE;
            end
            K_RET: begin
              pc_next = target;
              sp_next = sp - SP_ONE;
              if (occ == OC_ZERO) err_next = 1'b1;
              else                occ_next = occ - OC_ONE;
            end
            default: ;
          endcase
        end
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= RESET_VEC;
      ir        <= 14'h0000;
      sp        <= '0;
      occ       <= '0;
      squash    <= 1'b0;
      stack_err <= 1'b0;
      kind      <= K_SEQ;
      target    <= '0;
    end else if (!stall) begin
      state     <= state_next;
      pc        <= pc_next;
      sp        <= sp_next;
      occ       <= occ_next;
      squash    <= squash_next;
      stack_err <= err_next;
      if (state == FETCH) ir <= Rom_data_in;
      if (state == DECODE) begin
        kind   <= dec_kind;
        target <= dec_target;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !stall && push) stack[sp] <= pc_inc;
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_seq.sv
`default_nettype none
// tb_instr_fetch_seq : directed stimulus with an instruction-level reference model.
module tb_instr_fetch_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        skip_req = 1'b0;
  logic [10:0] rom_addr;
  logic [13:0] rom_data;
  logic [13:0] ir_out;
  logic        ir_valid;
  logic [10:0] pc_out;
  logic        stack_err;

  logic [13:0] rom [2048];
  assign rom_data = rom[rom_addr];

  instr_fetch_seq #(.RESET_VEC(11'h000), .STACK_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .Rom_addr_out(rom_addr), .Rom_data_in(rom_data),
    .stall(stall), .skip_req(skip_req), .ir_out(ir_out), .ir_valid(ir_valid),
    .pc_out(pc_out), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one instruction every three unstalled cycles.
  int          mpc, msp, mocc, ph, cyc;
  int          mstack [8];
  bit          merr, msq, mstarted = 0;
  logic [13:0] mir;

  initial for (int i = 0; i < 8; i++) mstack[i] = 0;

  always @(posedge clk) begin
    int npc, nsp, nocc;
    bit nerr;
    cyc <= reset ? 0 : cyc + 1;
    if (reset) begin
      mpc <= 0; mir <= 14'h0; ph <= 0; msp <= 0; mocc <= 0;
      merr <= 0; msq <= 0; mstarted <= 1;
    end else if (!stall && mstarted) begin
      if (ph == 0) mir <= rom[mpc];
      if (ph == 2) begin
        npc = (mpc + 1) % 2048; nsp = msp; nocc = mocc; nerr = merr;
        if (!msq) begin
          if (mir[13:11] == 3'b101) begin
            npc = int'(mir[10:0]);
          end else if (mir[13:11] == 3'b100) begin
            mstack[msp] <= (mpc + 1) % 2048;
            nsp = (msp + 1) % 8;
            if (mocc == 8) nerr = 1; else nocc = mocc + 1;
            npc = int'(mir[10:0]);
          end else if (mir == 14'h0008 || mir[13:10] == 4'b1101) begin
            nsp = (msp + 7) % 8;
            npc = mstack[nsp];
            if (mocc == 0) nerr = 1; else nocc = mocc - 1;
          end
        end
        mpc <= npc; msp <= nsp; mocc <= nocc; merr <= nerr;
        msq <= msq ? 1'b0 : skip_req;
      end
      ph <= (ph + 1) % 3;
    end
  end

  int log_pc[$], log_ir[$], log_cyc[$];
  bit seen [2048];

  always @(negedge clk) begin
    if (mstarted) begin
      chk("rom_addr", 32'(rom_addr), 32'(mpc));
      chk("ir_valid", 32'(ir_valid), 32'((ph == 2) && !msq));
      chk("stack_err", 32'(stack_err), 32'(merr));
      if (ph == 2 && !msq) begin
        chk("ir_out", 32'(ir_out), 32'(mir));
        chk("pc_out", 32'(pc_out), 32'(mpc));
      end
      if (!reset) seen[rom_addr] = 1'b1;
      if (ir_valid && !stall && !reset) begin
        log_pc.push_back(int'(pc_out));
        log_ir.push_back(int'(ir_out));
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic load_rom_clear();
    reset = 1'b1;
    for (int i = 0; i < 2048; i++) rom[i] = 14'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    skip_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    log_pc.delete(); log_ir.delete(); log_cyc.delete();
    for (int i = 0; i < 2048; i++) seen[i] = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Straight-line code: one instruction every 3 cycles.
    load_rom_clear();
    rom[0] = 14'h3001; rom[1] = 14'h3E02; rom[2] = 14'h3003; rom[3] = 14'h3004;
    do_reset();
    chk("rst_addr", 32'(rom_addr), 32'h0);
    chk("rst_valid", 32'(ir_valid), 32'h0);
    chk("rst_ir", 32'(ir_out), 32'h0);
    chk("rst_err", 32'(stack_err), 32'h0);
    step(12);
    chk("seq_addr4", 32'(rom_addr), 32'h4);
    chk("seq_count", 32'(log_pc.size()), 32'd4);
    if (log_pc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("seq_pc", 32'(log_pc[i]), 32'(i));
        chk("seq_cyc", 32'(log_cyc[i]), 32'(2 + 3 * i));
      end
      chk("seq_ir0", 32'(log_ir[0]), 32'h3001);
      chk("seq_ir1", 32'(log_ir[1]), 32'h3E02);
      chk("seq_ir3", 32'(log_ir[3]), 32'h3004);
    end

    // GOTO 5
    load_rom_clear();
    rom[0] = 14'h2805; rom[5] = 14'h3011;
    do_reset();
    step(7);
    chk("goto_count", 32'(log_pc.size()), 32'd2);
    if (log_pc.size() == 2) begin
      chk("goto_pc", 32'(log_pc[1]), 32'h5);
      chk("goto_ir", 32'(log_ir[1]), 32'h3011);
    end
    chk("goto_no_addr1", 32'(seen[1]), 32'h0);

    // CALL 4 / RETLW 77
    load_rom_clear();
    rom[0] = 14'h2004; rom[4] = 14'h3477; rom[1] = 14'h3001;
    do_reset();
    step(9);
    chk("call_count", 32'(log_pc.size()), 32'd3);
    if (log_pc.size() == 3) begin
      chk("call_pc0", 32'(log_pc[0]), 32'h0);
      chk("call_pc1", 32'(log_pc[1]), 32'h4);
      chk("call_ir1", 32'(log_ir[1]), 32'h3477);
      chk("call_pc2", 32'(log_pc[2]), 32'h1);
    end
    chk("call_err", 32'(stack_err), 32'h0);

    // Skip: instruction at 1 squashed; skip_req ignored in the squashed EXEC.
    load_rom_clear();
    rom[0] = 14'h3001; rom[1] = 14'h2805; rom[2] = 14'h3002;
    do_reset();
    step(2); skip_req = 1'b1;
    step(1); skip_req = 1'b0;
    step(2); skip_req = 1'b1;
    step(1); skip_req = 1'b0;
    step(3);
    chk("skip_count", 32'(log_pc.size()), 32'd2);
    if (log_pc.size() == 2) begin
      chk("skip_pc", 32'(log_pc[1]), 32'h2);
      chk("skip_ir", 32'(log_ir[1]), 32'h3002);
    end
    chk("skip_fetched1", 32'(seen[1]), 32'h1);
    chk("skip_no_addr5", 32'(seen[5]), 32'h0);
    chk("skip_addr3", 32'(rom_addr), 32'h3);

    // Nine nested CALLs overflow the 8-entry stack.
    load_rom_clear();
    for (int i = 0; i < 9; i++) rom[i] = 14'h2000 | 14'(i + 1);
    rom[9] = 14'h0008;
    do_reset();
    step(26);
    chk("ovf_before", 32'(stack_err), 32'h0);
    step(1);
    chk("ovf_after", 32'(stack_err), 32'h1);
    step(30);

    // RETURN on empty stack, then reset in EXEC.
    load_rom_clear();
    rom[0] = 14'h0008;
    do_reset();
    chk("unf_reset", 32'(stack_err), 32'h0);
    step(3);
    chk("unf_err", 32'(stack_err), 32'h1);
    step(2);
    chk("mid_exec_valid", 32'(ir_valid), 32'h1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("mid_rst_addr", 32'(rom_addr), 32'h0);
    chk("mid_rst_valid", 32'(ir_valid), 32'h0);
    chk("mid_rst_err", 32'(stack_err), 32'h0);
    step(6);

    // Stall for 4 cycles in DECODE, then for one cycle in EXEC.
    load_rom_clear();
    rom[0] = 14'h3001; rom[1] = 14'h3E02;
    do_reset();
    step(1); stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("stall_addr", 32'(rom_addr), 32'h0);
      chk("stall_ir", 32'(ir_out), 32'h3001);
      chk("stall_valid", 32'(ir_valid), 32'h0);
      chk("stall_pc", 32'(pc_out), 32'h0);
    end
    stall = 1'b0;
    step(1);
    chk("exec_valid", 32'(ir_valid), 32'h1);
    stall = 1'b1;
    step(1);
    chk("exec_stall_valid", 32'(ir_valid), 32'h1);
    stall = 1'b0;
    step(1);
    chk("after_stall_addr", 32'(rom_addr), 32'h1);
    chk("after_stall_valid", 32'(ir_valid), 32'h0);
    chk("stall_commits", 32'(log_pc.size()), 32'd1);
    step(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch_seq.md
Name: instr_fetch_seq

Overview:
- Instruction-sequencing controller for the 14-bit PIC-style core; owns the 11-bit program counter and drives the combinational program ROM address.
- Runs a 3-state fetch/decode/execute loop. Latches each ROM word into an instruction register and presents it to the ALU/datapath with a one-cycle valid strobe.
- Resolves control flow locally: GOTO, CALL, RETURN, RETLW, and skip requests from the datapath.
- Contains the 8-level hardware return stack.

Parameters:
- RESET_VEC, 11'h000, PC value loaded on reset.
- STACK_DEPTH, 8, return-stack entries; power of two.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Rom_addr_out  out  11  address to program ROM; combinational ROM returns data in the same cycle.
- Rom_data_in  in  14  instruction word from ROM.
- stall  in  1  when high, FSM and all registers hold.
- skip_req  in  1  datapath request to squash the next instruction; sampled only in EXEC with ir_valid=1.
- ir_out  out  14  current instruction register.
- ir_valid  out  1  high for exactly one EXEC cycle per non-squashed instruction.
- pc_out  out  11  address of the instruction in ir_out.
- stack_err  out  1  sticky overflow/underflow flag; cleared only by reset.

Behaviour:
- Reset (synchronous, overrides stall):
  - pc=RESET_VEC; ir=14'h0000; state=FETCH; sp=0; squash=0; stack_err=0.
  - ir_valid=0; Rom_addr_out=RESET_VEC.
- States:
  - FETCH: Rom_addr_out=pc; at the clock edge, ir<=Rom_data_in and go to DECODE.
  - DECODE: classify ir, compute next_pc; go to EXEC.
  - EXEC: ir_valid=~squash; at the clock edge, apply PC/stack update, squash<=skip_req&~squash, then go to FETCH.
- Throughput: 3 cycles per instruction.
  - First ir_valid occurs in the 3rd cycle after reset deasserts, i.e. cycle 2 counting from 0.
- Rom_addr_out always equals pc. pc changes only at the end of EXEC.
- Decode, applied in EXEC only when not squashed:
  - GOTO (ir[13:11]=3'b101): pc<=ir[10:0].
  - CALL (ir[13:11]=3'b100): stack[sp]<=pc+1; sp<=sp+1; pc<=ir[10:0].
  - RETURN (ir==14'h0008) or RETLW (ir[13:10]=4'b1101): sp<=sp-1; pc<=stack[sp-1]. RETLW literal is taken by the datapath from ir_out[7:0].
  - All other opcodes: pc<=pc+1.
- Squashed instruction: ir_valid=0, pc<=pc+1, no stack change. skip_req is ignored during a squashed EXEC.
- Width and wrap rules:
  - pc+1 is 11-bit; 11'h7FF wraps to 11'h000.
  - sp is log2(STACK_DEPTH) bits and wraps.
- Stack boundaries:
  - CALL with STACK_DEPTH entries already in use: overwrite at the wrapped position, set stack_err.
  - RETURN/RETLW with the stack empty: pop the wrapped entry, set stack_err.
  - An occupancy counter (0..STACK_DEPTH, saturating) tracks fullness independently of sp.
- stall: freezes state, pc, ir, sp, squash and stack.
  - ir_valid remains asserted while stalled in a non-squashed EXEC.
  - The datapath must treat only the cycle in which stall=0 as the commit.
- skip_req outside EXEC, or when ir_valid=0, has no effect.
- Reset mid-instruction (any state, any stall value): the next cycle is FETCH at RESET_VEC and the stack is emptied.

Test Plan:
- ROM {0:3001,1:3E02,2:3003,3:3004}, release reset:
  - ir_valid pulses at cycles 2, 5, 8, 11 with ir_out 3001, 3E02, 3003, 3004 and pc_out 0..3.
  - Rom_addr_out follows 0..4.
- ROM 0:2805 (GOTO 5), 5:3011:
  - after ir 2805 is valid, next Rom_addr_out=5 and ir_out=3011, pc_out=5.
  - address 1 is never fetched.
- ROM 0:2004 (CALL 4), 4:3477 (RETLW 77), 1:3001:
  - pc sequence 0, 4, 1; ir_out=3477 is valid at pc 4.
  - stack_err=0.
- skip_req=1 during EXEC of addr 0, ROM 1:2805:
  - addr 1 is fetched but ir_valid stays 0 for it; pc goes to 2, not 5.
- Nine nested CALLs (each target is another CALL): stack_err=1 after the 9th. Single RETURN from empty stack after reset: stack_err=1.
- Hold stall=1 for 4 cycles in DECODE: no outputs change. Assert reset during EXEC: next cycle FETCH with Rom_addr_out=000, ir_valid=0, stack_err=0.
